// File: rtl/sram_bist_ctrl_if.sv
// Single-port SRAM access bus between the BIST controller (master) and the
// SRAM array (slave). Read data returns one cycle after a read access.
interface sram_bist_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              en;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (output en, we, addr, wdata, input rdata);
  modport slave  (input en, we, addr, wdata, output rdata);
endinterface

// File: rtl/sram_bist_ctrl.sv
// March C- BIST controller. Drives the full M0..M5 address/data sequence on
// the SRAM bus, checks every read one cycle later against the expected
// background, and keeps pass/fail status plus first-failure diagnostics.
module sram_bist_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic              fail_o,
  output logic [ADDR_W-1:0] err_addr_o,
  output logic [DATA_W-1:0] err_exp_o,
  output logic [DATA_W-1:0] err_act_o,
  output logic [15:0]       err_cnt_o,
  sram_bist_ctrl_if.master  sram
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_M0    = 4'd1;
  localparam logic [3:0] S_M1    = 4'd2;
  localparam logic [3:0] S_M2    = 4'd3;
  localparam logic [3:0] S_M3    = 4'd4;
  localparam logic [3:0] S_M4    = 4'd5;
  localparam logic [3:0] S_M5    = 4'd6;
  localparam logic [3:0] S_DRAIN = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;

  localparam logic [ADDR_W-1:0] ADDR_FIRST = '0;
  localparam logic [ADDR_W-1:0] ADDR_LAST  = '1;
  localparam logic [DATA_W-1:0] D0         = '0;
  localparam logic [DATA_W-1:0] D1         = '1;

  logic [3:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              phase_q, phase_d;
  logic              start_acc;

  logic              op_en, op_we;
  logic [DATA_W-1:0] op_wdata;
  logic [DATA_W-1:0] rd_exp;
  logic              rd_issue;

  logic              chk_vld_q;
  logic [ADDR_W-1:0] chk_addr_q;
  logic [DATA_W-1:0] chk_exp_q;
  logic              mismatch;

  logic              fail_q;
  logic [ADDR_W-1:0] err_addr_q;
  logic [DATA_W-1:0] err_exp_q;
  logic [DATA_W-1:0] err_act_q;
  logic [15:0]       err_cnt_q;

  // Decode the SRAM access and expected read background for this cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a value held, which would otherwise infer a latch.
    op_en    = 1'b0;
    op_we    = 1'b0;
    op_wdata = '0;
    rd_exp   = '0;
    unique case (state_q)
      S_M0: begin
        op_en    = 1'b1;
        op_we    = 1'b1;
        op_wdata = D0;
      end
      S_M1, S_M3: begin
        op_en = 1'b1;
        if (phase_q) begin
          op_we    = 1'b1;
          op_wdata = D1;
        end else begin
          rd_exp = D0;
        end
      end
      S_M2, S_M4: begin
        op_en = 1'b1;
        if (phase_q) begin
          op_we    = 1'b1;
          op_wdata = D0;
        end else begin
          rd_exp = D1;
        end
      end
      S_M5: begin
        op_en  = 1'b1;
        rd_exp = D0;
      end
      default: ;
    endcase
  end

  assign rd_issue   = op_en & ~op_we;
  assign sram.en    = op_en;
  assign sram.we    = op_we;
  assign sram.addr  = op_en ? addr_q : '0;
  assign sram.wdata = op_wdata;

  // Sequence the March elements: address walk, read/write phase, element hops.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    phase_d   = phase_q;
    start_acc = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          start_acc = 1'b1;
          state_d   = S_M0;
          addr_d    = ADDR_FIRST;
          phase_d   = 1'b0;
        end
      end
      S_M0: begin
        if (addr_q == ADDR_LAST) begin
          state_d = S_M1;
          addr_d  = ADDR_FIRST;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_M1, S_M2: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          if (addr_q == ADDR_LAST) begin
            // M1 hands over to the ascending M2; M2 to the descending M3.
            state_d = (state_q == S_M1) ? S_M2 : S_M3;
            addr_d  = (state_q == S_M1) ? ADDR_FIRST : ADDR_LAST;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      S_M3, S_M4: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          if (addr_q == ADDR_FIRST) begin
            state_d = (state_q == S_M3) ? S_M4 : S_M5;
            addr_d  = ADDR_LAST;
          end else begin
            addr_d = addr_q - 1'b1;
          end
        end
      end
      S_M5: begin
        if (addr_q == ADDR_FIRST) begin
          state_d = S_DRAIN;
        end else begin
          addr_d = addr_q - 1'b1;
        end
      end
      S_DRAIN: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      addr_q  <= addr_d;
      phase_q <= phase_d;
    end
  end

  assign mismatch = chk_vld_q && (sram.rdata != chk_exp_q);

  // Read-check pipeline and sticky first-failure diagnostics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_vld_q  <= 1'b0;
      chk_addr_q <= '0;
      chk_exp_q  <= '0;
      fail_q     <= 1'b0;
      err_addr_q <= '0;
      err_exp_q  <= '0;
      err_act_q  <= '0;
      err_cnt_q  <= '0;
    end else if (start_acc) begin
      chk_vld_q  <= 1'b0;
      fail_q     <= 1'b0;
      err_addr_q <= '0;
      err_exp_q  <= '0;
      err_act_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      chk_vld_q <= rd_issue;
      if (rd_issue) begin
        chk_addr_q <= addr_q;
        chk_exp_q  <= rd_exp;
      end
      if (mismatch) begin
        fail_q <= 1'b1;
        if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
        // Only the first mismatch of a run is captured.
        if (!fail_q) begin
          err_addr_q <= chk_addr_q;
          err_exp_q  <= chk_exp_q;
          err_act_q  <= sram.rdata;
        end
      end
    end
  end

  assign busy_o     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o     = (state_q == S_DONE);
  assign pass_o     = done_o & ~fail_q;
  assign fail_o     = fail_q;
  assign err_addr_o = err_addr_q;
  assign err_exp_o  = err_exp_q;
  assign err_act_o  = err_act_q;
  assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_sram_bist_ctrl.sv
// Bench for sram_bist_ctrl: SRAM model with an injectable stuck-at bit, an
// expected-access scoreboard for the March C- sequence, and result checks.
module tb_sram_bist_ctrl;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              rst_n;
  logic              start_i;
  logic              busy_o, done_o, pass_o, fail_o;
  logic [ADDR_W-1:0] err_addr_o;
  logic [DATA_W-1:0] err_exp_o, err_act_o;
  logic [15:0]       err_cnt_o;

  sram_bist_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) sram_if ();

  sram_bist_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .pass_o     (pass_o),
    .fail_o     (fail_o),
    .err_addr_o (err_addr_o),
    .err_exp_o  (err_exp_o),
    .err_act_o  (err_act_o),
    .err_cnt_o  (err_cnt_o),
    .sram       (sram_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model with one faulty address: sa1 bits forced high, sa0 bits low.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] f_addr;
  logic [DATA_W-1:0] sa1_mask, sa0_mask;

  always_ff @(posedge clk) begin
    if (sram_if.en && sram_if.we) mem[sram_if.addr] <= sram_if.wdata;
    if (sram_if.en && !sram_if.we) begin
      if (sram_if.addr == f_addr)
        sram_if.rdata <= (mem[sram_if.addr] | sa1_mask) & ~sa0_mask;
      else
        sram_if.rdata <= mem[sram_if.addr];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected access stream {we, addr, wdata}; reads carry wdata = 0.
  logic [ADDR_W+DATA_W:0] exp_q [$];

  task automatic build_expected();
    logic [ADDR_W-1:0] a;
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      a = ADDR_W'(i);
      exp_q.push_back({1'b1, a, 8'h00});
    end
    for (int i = 0; i < DEPTH; i++) begin
      a = ADDR_W'(i);
      exp_q.push_back({1'b0, a, 8'h00});
      exp_q.push_back({1'b1, a, 8'hFF});
    end
    for (int i = 0; i < DEPTH; i++) begin
      a = ADDR_W'(i);
      exp_q.push_back({1'b0, a, 8'h00});
      exp_q.push_back({1'b1, a, 8'h00});
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      a = ADDR_W'(i);
      exp_q.push_back({1'b0, a, 8'h00});
      exp_q.push_back({1'b1, a, 8'hFF});
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      a = ADDR_W'(i);
      exp_q.push_back({1'b0, a, 8'h00});
      exp_q.push_back({1'b1, a, 8'h00});
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      a = ADDR_W'(i);
      exp_q.push_back({1'b0, a, 8'h00});
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({busy_o, done_o, pass_o, fail_o, err_addr_o, err_exp_o, err_act_o,
                err_cnt_o, sram_if.en, sram_if.we, sram_if.addr, sram_if.wdata});
  endfunction

  // One BIST run: pulse (or hold) start, score every SRAM access, then check
  // the result. abort_at > 0 pulls rst_n low in that cycle instead.
  task automatic run(input string tag, input bit hold, input int abort_at,
                     input logic exp_fail, input logic [15:0] exp_cnt,
                     input logic [ADDR_W-1:0] exp_addr,
                     input logic [DATA_W-1:0] exp_e, input logic [DATA_W-1:0] exp_a);
    int busy_n = 0;
    int wr_n   = 0;
    int rd_n   = 0;
    bit finished = 1'b0;
    bit aborted  = 1'b0;
    logic [ADDR_W+DATA_W+1:0] obs, exp;
    build_expected();
    @(negedge clk);
    start_i = 1'b1;
    for (int k = 1; k <= 400 && !finished; k++) begin
      @(negedge clk);
      if (!hold) start_i = 1'b0;
      if (k == abort_at) begin
        #2 rst_n = 1'b0;
        #1 check({tag, "_abort_outputs"}, all_outs(), 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        aborted  = 1'b1;
        finished = 1'b1;
      end else if (done_o) begin
        start_i  = 1'b0;
        finished = 1'b1;
      end else begin
        if (busy_o) busy_n++;
        if (sram_if.en) begin
          if (sram_if.we) wr_n++;
          else rd_n++;
          obs = {1'b0, sram_if.we, sram_if.addr, sram_if.wdata};
          exp = (exp_q.size() != 0) ? {1'b0, exp_q.pop_front()} : '1;
          check({tag, "_access"}, 64'(obs), 64'(exp));
        end
      end
    end
    if (!aborted) begin
      check({tag, "_done"},      64'(done_o),     64'd1);
      check({tag, "_busy_low"},  64'(busy_o),     64'd0);
      check({tag, "_busy_cyc"},  64'(busy_n),     64'(10 * DEPTH + 1));
      check({tag, "_writes"},    64'(wr_n),       64'(5 * DEPTH));
      check({tag, "_reads"},     64'(rd_n),       64'(5 * DEPTH));
      check({tag, "_left"},      64'(exp_q.size()), 64'd0);
      check({tag, "_fail"},      64'(fail_o),     64'(exp_fail));
      check({tag, "_pass"},      64'(pass_o),     64'(!exp_fail));
      check({tag, "_err_cnt"},   64'(err_cnt_o),  64'(exp_cnt));
      check({tag, "_err_addr"},  64'(err_addr_o), 64'(exp_addr));
      check({tag, "_err_exp"},   64'(err_exp_o),  64'(exp_e));
      check({tag, "_err_act"},   64'(err_act_o),  64'(exp_a));
    end
  endtask

  task automatic set_fault(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] s1,
                           input logic [DATA_W-1:0] s0);
    f_addr   = a;
    sa1_mask = s1;
    sa0_mask = s0;
  endtask

  initial begin
    rst_n   = 1'b0;
    start_i = 1'b0;
    set_fault('0, '0, '0);
    #12 check("reset_outputs", all_outs(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fault-free run.
    run("clean", 1'b0, 0, 1'b0, 16'd0, 4'd0, 8'h00, 8'h00);

    // Bit 0 stuck-at-1 at address 5: seen in M1, M3, M5.
    set_fault(4'd5, 8'h01, 8'h00);
    run("sa1_a5", 1'b0, 0, 1'b1, 16'd3, 4'd5, 8'h00, 8'h01);

    // Bit 7 stuck-at-0 at address 15: seen in M2, M4.
    set_fault(4'd15, 8'h00, 8'h80);
    run("sa0_a15", 1'b0, 0, 1'b1, 16'd2, 4'd15, 8'hFF, 8'h7F);

    // Restart from a failed DONE with start held high the whole run.
    set_fault('0, '0, '0);
    run("hold_clear", 1'b1, 0, 1'b0, 16'd0, 4'd0, 8'h00, 8'h00);

    // Reset in cycle 50 of a run that has already logged a mismatch.
    set_fault(4'd5, 8'h01, 8'h00);
    run("abort", 1'b0, 50, 1'b0, 16'd0, 4'd0, 8'h00, 8'h00);

    // Full run after the abort.
    set_fault('0, '0, '0);
    run("post_abort", 1'b0, 0, 1'b0, 16'd0, 4'd0, 8'h00, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
